// File: rtl/mac_dot_sequencer_pkg.sv
// Shared types and width helpers for the MAC dot-product sequencer.
package mac_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        ISSUE  = 3'd2,
        DRAIN  = 3'd3,
        RESULT = 3'd4
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // MAC result width: one double-width product plus DATA_WIDTH bits of accumulation headroom.
    function automatic int res_width(input int data_width);
        return 3 * data_width;
    endfunction

    localparam int RES_WIDTH = res_width(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/mac_dot_sequencer_if.sv
// Bundles the operand streams, MAC drive/return and result port of the sequencer.
interface mac_dot_sequencer_if
    import mac_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8
);
    localparam int RW = res_width(DATA_WIDTH);

    logic                  start;
    logic                  busy;
    logic [DATA_WIDTH-1:0] a_data;
    logic                  a_valid;
    logic                  a_ready;
    logic [DATA_WIDTH-1:0] b_data;
    logic                  b_valid;
    logic                  b_ready;
    logic [DATA_WIDTH-1:0] mac_ain;
    logic [DATA_WIDTH-1:0] mac_bin;
    logic                  mac_en;
    logic                  mac_clr;
    logic [RW-1:0]         mac_cout;
    logic [RW-1:0]         res_data;
    logic                  res_valid;
    logic                  res_ready;
    logic                  done;
    state_t                dbg_state;

    modport master (
        input  start, a_data, a_valid, b_data, b_valid, mac_cout, res_ready,
        output busy, a_ready, b_ready, mac_ain, mac_bin, mac_en, mac_clr,
               res_data, res_valid, done, dbg_state
    );

    modport slave (
        output start, a_data, a_valid, b_data, b_valid, mac_cout, res_ready,
        input  busy, a_ready, b_ready, mac_ain, mac_bin, mac_en, mac_clr,
               res_data, res_valid, done, dbg_state
    );

endinterface

// File: rtl/mac_dot_sequencer.sv
// Feeds VEC_LEN operand pairs into an external MAC with matching En timing
// and returns the accumulated Cout on a valid/ready result port.
module mac_dot_sequencer
    import mac_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mac_dot_sequencer_if.master bus
);
    localparam int RW = res_width(DATA_WIDTH);
    localparam int CW = $clog2(VEC_LEN + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(VEC_LEN - 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  iss_d1_q, iss_d1_d;
    logic                  mac_en_q, mac_en_d;
    logic                  mac_clr_q, mac_clr_d;
    logic [DATA_WIDTH-1:0] ain_q, ain_d;
    logic [DATA_WIDTH-1:0] bin_q, bin_d;
    logic [RW-1:0]         res_data_q, res_data_d;
    logic                  res_valid_q, res_valid_d;
    logic                  done_q, done_d;
    logic                  fire;

    // Valid/ready: a transfer happens on any cycle where valid and ready are both
    // high at the clock edge. Operands move only as a pair, so both readies equal
    // the joint fire and never depend on just one side; res_valid holds until taken.
    always_comb begin
        fire        = (state_q == ISSUE) && bus.a_valid && bus.b_valid;
        state_d     = state_q;
        count_d     = count_q;
        ain_d       = ain_q;
        bin_d       = bin_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        done_d      = 1'b0;
        mac_clr_d   = 1'b0;
        iss_d1_d    = fire;
        mac_en_d    = iss_d1_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = CLEAR;
                    mac_clr_d = 1'b1;
                end
            end
            CLEAR: begin
                count_d = '0;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (fire) begin
                    ain_d   = bus.a_data;
                    bin_d   = bus.b_data;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Both delay flops empty means the last product has reached Cout.
                if (!iss_d1_q && !mac_en_q) begin
                    res_data_d  = bus.mac_cout;
                    res_valid_d = 1'b1;
                    state_d     = RESULT;
                end
            end
            RESULT: begin
                if (res_valid_q && bus.res_ready) begin
                    res_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            iss_d1_q    <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_clr_q   <= 1'b0;
            ain_q       <= '0;
            bin_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            iss_d1_q    <= iss_d1_d;
            mac_en_q    <= mac_en_d;
            mac_clr_q   <= mac_clr_d;
            ain_q       <= ain_d;
            bin_q       <= bin_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.a_ready   = fire;
    assign bus.b_ready   = fire;
    assign bus.mac_ain   = ain_q;
    assign bus.mac_bin   = bin_q;
    assign bus.mac_en    = mac_en_q;
    assign bus.mac_clr   = mac_clr_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_valid = res_valid_q;
    assign bus.done      = done_q;
    assign bus.dbg_state = state_q;

endmodule
